result_accumulator: RTL and testbench
=====================================

# result_accumulator

Downstream consumer of the registered adder stage's result interface. Takes its one-cycle `valid`/`y` result pulses, sums every N consecutive results into a widened group total, and buffers totals in a small FIFO for a ready/valid consumer. The upstream adder cannot be stalled, so the input never back-pressures; loss is flagged instead.

## Interface

Parameters:
- `W`, 12: result width from the upstream adder.
- `N`, 4: results per group, N ≥ 1.
- `DEPTH`, 4: FIFO entries, DEPTH ≥ 2.
- `ACC_W`, W + $clog2(N): group-sum width. Derived, not overridden.

Ports:
- `clk`, input, 1: single clock. All logic is on posedge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `in_valid`, input, 1: upstream result valid (the adder's `valid`).
- `in_y`, input, W: upstream result (the adder's `y`). Sampled only when `in_valid`=1.
- `out_valid`, output, 1: FIFO head holds a group sum.
- `out_ready`, input, 1: consumer accepts the head when `out_valid`=1.
- `out_sum`, output, ACC_W: head group sum. Forced to 0 when `out_valid`=0.
- `fifo_level`, output, $clog2(DEPTH+1): number of occupied entries.
- `overflow`, output, 1: sticky flag, set when a group is dropped.

## Operation

- **Accumulator:** register `acc` (ACC_W bits) plus group counter `cnt` (0..N-1).
  - Each `in_valid` cycle with cnt < N-1: `acc` <= `acc` + zero-extended `in_y`, and `cnt` increments.
  - When cnt = N-1: group completes. The push value is `acc` + `in_y`, then `acc` <= 0 and `cnt` <= 0.
  - Gaps in `in_valid` hold `acc` and `cnt` unchanged. There is no timeout.
- **Width:** ACC_W covers N·(2^W−1), so the sum never wraps and no saturation logic is needed.
- **Push / pop:**
  - A completed group is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Pop occurs when `out_valid` && `out_ready`.
- **Full, no pop:**
  - The completed group is discarded.
  - `overflow` <= 1 and stays set until reset.
  - FIFO contents are unchanged.
  - `acc` and `cnt` still restart from 0.
- **Empty with push:** no combinational bypass. The entry is visible the following cycle.
- **Ordering:** strict FIFO, so groups are delivered in completion order.
- **Reset** (`rst_n`=0 at a posedge):
  - `acc`=0, `cnt`=0, FIFO emptied, `fifo_level`=0.
  - `out_valid`=0, `out_sum`=0, `overflow`=0.
  - A partial group in progress is discarded. Inputs are ignored in that cycle.

## Timing

- The Nth sample is accepted at edge t. At edge t the sum is written into the FIFO, so from t+1 `out_valid`=1, `out_sum` = group total, and `fifo_level` is incremented.
- Pop at edge t: the next entry, or `out_valid`=0, is visible after t.
- Simultaneous push and pop:
  - `fifo_level` is unchanged.
  - With level 1, the head is replaced by the new sum after the edge. `out_valid` stays 1.
- `out_valid` is a registered function of `fifo_level`. `out_sum` comes directly from the head storage through the empty-mask gate.
- While `out_valid`=1 and `out_ready`=0, `out_sum` is stable.
- Throughput: one sample per cycle in, one group per cycle out.

## Structure

- **Package `result_acc_pkg`:**
  - Default constants `RA_W`=12, `RA_N`=4, `RA_DEPTH`=4.
  - Function `acc_width(w, n)` returning w + $clog2(n).
- **Sub-module `result_fifo`:**
  - Parameterised width/depth synchronous FIFO.
  - Synchronous active-low reset.
  - Ports: push, push_data, pop, head_data, level, full, empty.
  - Occupancy is tracked with a level counter. Read/write pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
- **Top:** holds the accumulator, the group counter, the overflow flag, and the output gating.

## Test plan

Configuration for all scenarios: W=12, N=4, DEPTH=4.

1. **Reset:** hold `rst_n`=0 for 3 cycles with random `in_valid`/`in_y` → `out_valid`=0, `out_sum`=0, `fifo_level`=0, `overflow`=0 throughout.
2. **Basic group:** `in_y`=1,2,3,4 on consecutive `in_valid` cycles with `out_ready`=1 → `out_valid`=1 for exactly one cycle, starting the cycle after the 4th sample, with `out_sum`=10. Repeat with idle gaps between samples → same result.
3. **Width:** four samples of 4095 → `out_sum`=16380 (14-bit), with no wrap.
4. **Overflow:**
   - Drive 5 groups with `out_ready`=0. Groups 1–4 are 10, 26, 42, 58 (samples 1..20).
   - Expect `fifo_level`=4, group 5 dropped, and `overflow`=1 from the cycle after the 20th sample.
   - Raise `out_ready` → outputs 10, 26, 42, 58 in order. `overflow` stays 1.
5. **Full with concurrent pop:** FIFO full and `out_ready`=1 in the cycle a group completes → push accepted, `fifo_level` stays 4, `overflow` stays 0, and the new sum appears last in drain order.
6. **Reset mid-group:**
   - Samples 7, 9, then `rst_n`=0 for one cycle, then samples 1, 1, 1, 1.
   - Expected result: `out_sum`=4, since the partial sum 16 is discarded, and `overflow`=0.

Source files
------------

// File: rtl/result_acc_pkg.sv
// Shared defaults and width helper for the result accumulator slice.
package result_acc_pkg;

    localparam int RA_W     = 12;
    localparam int RA_N     = 4;
    localparam int RA_DEPTH = 4;

    // Group-sum width large enough that n full-scale w-bit results never wrap.
    function automatic int acc_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with level-counter occupancy; pointers wrap modulo DEPTH.
module result_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/result_accumulator.sv
// Sums every N upstream results into a widened group total and queues totals for a ready/valid consumer.
module result_accumulator
    import result_acc_pkg::*;
#(
    parameter  int W     = RA_W,
    parameter  int N     = RA_N,
    parameter  int DEPTH = RA_DEPTH,
    localparam int ACC_W = acc_width(W, N),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
    logic [ACC_W-1:0] sum_next;
    logic [ACC_W-1:0] head_data;
    logic             last, grp_done, pop, push, full, empty;

    assign sum_next = acc_q + ACC_W'(in_y);
    assign last     = (cnt_q == CNT_W'(N - 1));
    assign grp_done = in_valid && last;
    assign pop      = out_valid && out_ready;
    assign push     = grp_done && (!full || pop);

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (in_valid) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A completed group with nowhere to go is dropped, and that is remembered.
        if (grp_done && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    result_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sum_next),
        .pop       (pop),
        .head_data (head_data),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid = !empty;
    assign out_sum   = out_valid ? head_data : '0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed self-checking bench for result_accumulator (W=12, N=4, DEPTH=4).
module tb_result_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_sum;
    logic [2:0]  fifo_level;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [11:0] y;
        logic        rdy;
        logic        ev;
        int          es;
        int          el;
        logic        eo;
    } vec_t;

    vec_t tbl[$];

    result_accumulator #(
        .W     (12),
        .N     (4),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%0d req=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic ev, input int es, input int el, input logic eo);
        chk({name, ".valid"}, int'(out_valid), int'(ev));
        chk({name, ".sum"},   int'(out_sum),   es);
        chk({name, ".level"}, int'(fifo_level), el);
        chk({name, ".ovf"},   int'(overflow),  int'(eo));
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic r, input logic v, input logic [11:0] y, input logic rdy);
        rst_n     = r;
        in_valid  = v;
        in_y      = y;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic v, input int y, input logic rdy,
                       input logic ev, input int es, input int el, input logic eo);
        vec_t t;
        t.rst_n = r; t.v = v; t.y = 12'(y); t.rdy = rdy;
        t.ev = ev; t.es = es; t.el = el; t.eo = eo;
        tbl.push_back(t);
    endtask

    int exp_q[4];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_y = '0; out_ready = 1'b0;

        // Reset with live inputs.
        add(0, 1,    5, 1,  0,     0, 0, 0);
        add(0, 1,   77, 0,  0,     0, 0, 0);
        add(0, 1, 4095, 1,  0,     0, 0, 0);
        // Basic group, back-to-back.
        add(1, 1,    1, 1,  0,     0, 0, 0);
        add(1, 1,    2, 1,  0,     0, 0, 0);
        add(1, 1,    3, 1,  0,     0, 0, 0);
        add(1, 1,    4, 1,  1,    10, 1, 0);
        add(1, 0,    0, 1,  0,     0, 0, 0);
        // Same group with idle gaps; in_y ignored when not valid.
        add(1, 1,    1, 1,  0,     0, 0, 0);
        add(1, 0,    9, 1,  0,     0, 0, 0);
        add(1, 1,    2, 1,  0,     0, 0, 0);
        add(1, 0,  100, 1,  0,     0, 0, 0);
        add(1, 1,    3, 1,  0,     0, 0, 0);
        add(1, 0,    0, 1,  0,     0, 0, 0);
        add(1, 1,    4, 1,  1,    10, 1, 0);
        add(1, 0,    0, 1,  0,     0, 0, 0);
        // Full-scale width.
        add(1, 1, 4095, 1,  0,     0, 0, 0);
        add(1, 1, 4095, 1,  0,     0, 0, 0);
        add(1, 1, 4095, 1,  0,     0, 0, 0);
        add(1, 1, 4095, 1,  1, 16380, 1, 0);
        add(1, 0,    0, 1,  0,     0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].v, tbl[i].y, tbl[i].rdy);
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].el, tbl[i].eo);
        end

        // Overflow: five groups with consumer stalled, fifth dropped.
        exp_q = '{10, 26, 42, 58};
        step(0, 0, 0, 0);
        for (int s = 1; s <= 20; s++) begin
            step(1, 1, 12'(s), 0);
            if (s == 16) chk_all("ovf.full", 1, 10, 4, 0);
        end
        chk_all("ovf.drop", 1, 10, 4, 1);
        for (int k = 0; k < 4; k++) begin
            chk_all($sformatf("ovf.drain%0d", k), 1, exp_q[k], 4 - k, 1);
            step(1, 0, 0, 1);
        end
        chk_all("ovf.empty", 0, 0, 0, 1);

        // Full FIFO with a pop in the same cycle a group completes.
        step(0, 0, 0, 0);
        chk_all("fp.reset", 0, 0, 0, 0);
        for (int s = 1; s <= 16; s++) step(1, 1, 12'(s), 0);
        chk_all("fp.full", 1, 10, 4, 0);
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        step(1, 1, 1, 1);
        chk_all("fp.swap", 1, 26, 4, 0);
        exp_q = '{26, 42, 58, 4};
        step(1, 0, 0, 0);
        chk_all("fp.hold", 1, 26, 4, 0);
        for (int k = 0; k < 4; k++) begin
            chk_all($sformatf("fp.drain%0d", k), 1, exp_q[k], 4 - k, 0);
            step(1, 0, 0, 1);
        end
        chk_all("fp.empty", 0, 0, 0, 0);

        // Reset mid-group discards the partial sum.
        step(1, 1, 7, 1);
        step(1, 1, 9, 1);
        step(0, 1, 100, 1);
        chk_all("rmg.reset", 0, 0, 0, 0);
        for (int s = 0; s < 4; s++) step(1, 1, 1, 1);
        chk_all("rmg.sum", 1, 4, 1, 0);

        // Level-1 push with pop: head replaced, stable while stalled.
        step(1, 1, 2, 0);
        step(1, 1, 2, 0);
        step(1, 1, 2, 0);
        chk_all("l1.stall", 1, 4, 1, 0);
        step(1, 1, 2, 1);
        chk_all("l1.swap", 1, 8, 1, 0);
        step(1, 0, 0, 1);
        chk_all("l1.empty", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
